// File: rtl/packet_serializer.sv
// packet_serializer: replays one captured scheduler packet as AXI4 master
// traffic -- AW followed by 1..4 W beats for writes, a single AR for reads --
// and pulses `consumed` once the last handshake of that packet completes.
module packet_serializer #(
  parameter int DATA_SIZE  = 678,
  parameter int ID_WIDTH   = 16,
  parameter int ADDR_WIDTH = 40
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_SIZE-1:0]  packet,
  input  logic                  activate,
  output logic                  consumed,
  // write address channel
  output logic [ID_WIDTH-1:0]   m_awid,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [7:0]            m_awlen,
  output logic [2:0]            m_awsize,
  output logic [1:0]            m_awburst,
  output logic                  m_awlock,
  output logic [3:0]            m_awcache,
  output logic [2:0]            m_awprot,
  output logic [3:0]            m_awqos,
  output logic [3:0]            m_awregion,
  output logic [15:0]           m_awuser,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  // read address channel
  output logic [ID_WIDTH-1:0]   m_arid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic                  m_arlock,
  output logic [3:0]            m_arcache,
  output logic [2:0]            m_arprot,
  output logic [3:0]            m_arqos,
  output logic [3:0]            m_arregion,
  output logic [15:0]           m_aruser,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  // write data channel
  output logic [127:0]          m_wdata,
  output logic [15:0]           m_wstrb,
  output logic                  m_wlast,
  output logic                  m_wvalid,
  input  logic                  m_wready
);

  localparam int HDR_W    = 102;
  localparam int BEATS    = 4;
  localparam int STRB_W   = 16;
  localparam int DATA_W   = 128;
  localparam int STRB_LSB = HDR_W;
  localparam int DATA_LSB = STRB_LSB + BEATS*STRB_W;

  // Header layout, MSB first so the packed struct lines up with packet[101:0].
  typedef struct packed {
    logic        is_read;
    logic [15:0] user;
    logic [3:0]  region;
    logic        lock;
    logic [3:0]  qos;
    logic [2:0]  prot;
    logic [3:0]  cache;
    logic [15:0] id;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [39:0] addr;
  } hdr_t;

  typedef enum logic [1:0] {IDLE, AW, W, AR} state_t;

  hdr_t                          hdr_in;
  logic [BEATS-1:0][DATA_W-1:0]  data_in;
  logic [BEATS-1:0][STRB_W-1:0]  strb_in;

  // Captured beat payloads; the header goes straight into the AW/AR registers.
  logic [BEATS-1:0][DATA_W-1:0]  data_q;
  logic [BEATS-1:0][STRB_W-1:0]  strb_q;
  logic [1:0]                    last_q;
  logic [1:0]                    beat;
  logic [1:0]                    beat_nxt;
  state_t                        state;

  // Only len[1:0] sets the burst length; the upper len bits are dropped.
  logic unused_len;

  assign hdr_in     = hdr_t'(packet[HDR_W-1:0]);
  assign beat_nxt   = beat + 2'd1;
  assign unused_len = ^hdr_in.len[7:2];

  // Slice the per-beat strobe and data lanes out of the flat packet.
  for (genvar k = 0; k < BEATS; k++) begin : g_lane
    assign data_in[k] = packet[DATA_LSB + DATA_W*k +: DATA_W];
    assign strb_in[k] = packet[STRB_LSB + STRB_W*k +: STRB_W];
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      beat       <= '0;
      last_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      consumed   <= 1'b0;
      m_awid     <= '0;
      m_awaddr   <= '0;
      m_awlen    <= '0;
      m_awsize   <= '0;
      m_awburst  <= '0;
      m_awlock   <= 1'b0;
      m_awcache  <= '0;
      m_awprot   <= '0;
      m_awqos    <= '0;
      m_awregion <= '0;
      m_awuser   <= '0;
      m_awvalid  <= 1'b0;
      m_arid     <= '0;
      m_araddr   <= '0;
      m_arlen    <= '0;
      m_arsize   <= '0;
      m_arburst  <= '0;
      m_arlock   <= 1'b0;
      m_arcache  <= '0;
      m_arprot   <= '0;
      m_arqos    <= '0;
      m_arregion <= '0;
      m_aruser   <= '0;
      m_arvalid  <= 1'b0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
      m_wlast    <= 1'b0;
      m_wvalid   <= 1'b0;
    end else begin
      consumed <= 1'b0;
      case (state)
        IDLE: begin
          // The consumed cycle is skipped so the scheduler can move on first.
          if (activate && !consumed) begin
            data_q <= data_in;
            strb_q <= strb_in;
            last_q <= hdr_in.len[1:0];
            if (hdr_in.is_read) begin
              m_arid     <= ID_WIDTH'(hdr_in.id);
              m_araddr   <= ADDR_WIDTH'(hdr_in.addr);
              m_arlen    <= {6'b0, hdr_in.len[1:0]};
              m_arsize   <= hdr_in.size;
              m_arburst  <= hdr_in.burst;
              m_arlock   <= hdr_in.lock;
              m_arcache  <= hdr_in.cache;
              m_arprot   <= hdr_in.prot;
              m_arqos    <= hdr_in.qos;
              m_arregion <= hdr_in.region;
              m_aruser   <= hdr_in.user;
              m_arvalid  <= 1'b1;
              state      <= AR;
            end else begin
              m_awid     <= ID_WIDTH'(hdr_in.id);
              m_awaddr   <= ADDR_WIDTH'(hdr_in.addr);
              m_awlen    <= {6'b0, hdr_in.len[1:0]};
              m_awsize   <= hdr_in.size;
              m_awburst  <= hdr_in.burst;
              m_awlock   <= hdr_in.lock;
              m_awcache  <= hdr_in.cache;
              m_awprot   <= hdr_in.prot;
              m_awqos    <= hdr_in.qos;
              m_awregion <= hdr_in.region;
              m_awuser   <= hdr_in.user;
              m_awvalid  <= 1'b1;
              state      <= AW;
            end
          end
        end
        AW: begin
          // Beat 0 is staged in the same edge that retires AW.
          if (m_awready) begin
            m_awvalid <= 1'b0;
            beat      <= '0;
            m_wdata   <= data_q[0];
            m_wstrb   <= strb_q[0];
            m_wlast   <= (last_q == 2'd0);
            m_wvalid  <= 1'b1;
            state     <= W;
          end
        end
        W: begin
          if (m_wready) begin
            if (beat == last_q) begin
              m_wvalid <= 1'b0;
              m_wlast  <= 1'b0;
              beat     <= '0;
              consumed <= 1'b1;
              state    <= IDLE;
            end else begin
              beat    <= beat_nxt;
              m_wdata <= data_q[beat_nxt];
              m_wstrb <= strb_q[beat_nxt];
              m_wlast <= (beat_nxt == last_q);
            end
          end
        end
        AR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            consumed  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_serializer.sv
// Directed bench for packet_serializer. Inputs change on the falling edge,
// outputs are checked on the falling edge (mid-cycle).
module tb_packet_serializer;

  logic         clock, reset;
  logic [677:0] packet;
  logic         activate, consumed;
  logic [15:0]  m_awid, m_arid, m_awuser, m_aruser;
  logic [39:0]  m_awaddr, m_araddr;
  logic [7:0]   m_awlen, m_arlen;
  logic [2:0]   m_awsize, m_arsize, m_awprot, m_arprot;
  logic [1:0]   m_awburst, m_arburst;
  logic         m_awlock, m_arlock;
  logic [3:0]   m_awcache, m_arcache, m_awqos, m_arqos, m_awregion, m_arregion;
  logic         m_awvalid, m_awready, m_arvalid, m_arready;
  logic [127:0] m_wdata;
  logic [15:0]  m_wstrb;
  logic         m_wlast, m_wvalid, m_wready;

  int checks = 0;
  int errors = 0;

  packet_serializer dut (
    .clock(clock), .reset(reset), .packet(packet), .activate(activate), .consumed(consumed),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_awqos(m_awqos), .m_awregion(m_awregion), .m_awuser(m_awuser),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arqos(m_arqos), .m_arregion(m_arregion), .m_aruser(m_aruser),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Beat k data is 16 copies of byte (seed + 0x11*k).
  function automatic logic [127:0] bdata(input logic [7:0] seed, input int k);
    logic [7:0] b;
    b = seed + 8'(k * 8'h11);
    return {16{b}};
  endfunction

  // Fixed side fields: size=4 burst=1 cache=3 prot=2 qos=5 lock=0 region=6 user=BEEF.
  function automatic logic [677:0] mk_pkt(input logic rd, input logic [39:0] addr,
                                          input logic [7:0] len, input logic [15:0] id,
                                          input logic [15:0] strb, input logic [7:0] seed);
    logic [677:0] p;
    p = '0;
    p[39:0]   = addr;
    p[47:40]  = len;
    p[50:48]  = 3'd4;
    p[52:51]  = 2'd1;
    p[68:53]  = id;
    p[72:69]  = 4'h3;
    p[75:73]  = 3'h2;
    p[79:76]  = 4'h5;
    p[80]     = 1'b0;
    p[84:81]  = 4'h6;
    p[100:85] = 16'hBEEF;
    p[101]    = rd;
    for (int k = 0; k < 4; k++) begin
      p[102 + 16*k +: 16]  = strb ^ 16'(k);
      p[166 + 128*k +: 128] = bdata(seed, k);
    end
    return p;
  endfunction

  initial begin
    reset = 1'b0; activate = 1'b0; packet = '0;
    m_awready = 1'b1; m_arready = 1'b1; m_wready = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_wlast", m_wlast, 0);
    chk("rst_consumed", consumed, 0);
    chk("rst_awaddr", m_awaddr, 0);
    chk("rst_wdata", m_wdata, 0);
    reset = 1'b1;
    @(negedge clock);

    // ---- write len=3, readies high ----
    packet = mk_pkt(1'b0, 40'h12_3456_7800, 8'd3, 16'h00A5, 16'hFFFF, 8'h11);
    activate = 1'b1;
    @(negedge clock);                       // cycle 1
    activate = 1'b0;
    chk("w1_awvalid", m_awvalid, 1);
    chk("w1_awaddr", m_awaddr, 40'h12_3456_7800);
    chk("w1_awlen", m_awlen, 3);
    chk("w1_awid", m_awid, 16'h00A5);
    chk("w1_awsize", m_awsize, 4);
    chk("w1_awburst", m_awburst, 1);
    chk("w1_awcache", m_awcache, 3);
    chk("w1_awprot", m_awprot, 2);
    chk("w1_awqos", m_awqos, 5);
    chk("w1_awlock", m_awlock, 0);
    chk("w1_awregion", m_awregion, 6);
    chk("w1_awuser", m_awuser, 16'hBEEF);
    chk("w1_wvalid_early", m_wvalid, 0);
    chk("w1_arvalid", m_arvalid, 0);
    for (int k = 0; k < 4; k++) begin       // cycles 2..5
      @(negedge clock);
      chk("w1_wvalid", m_wvalid, 1);
      chk("w1_wdata", m_wdata, {16{8'(8'h11 * (k + 1))}});
      chk("w1_wstrb", m_wstrb, 16'hFFFF ^ 16'(k));
      chk("w1_wlast", m_wlast, k == 3);
      chk("w1_awvalid_off", m_awvalid, 0);
      chk("w1_consumed_early", consumed, 0);
    end
    @(negedge clock);                       // cycle 6
    chk("w1_consumed", consumed, 1);
    chk("w1_wvalid_end", m_wvalid, 0);
    @(negedge clock);
    chk("w1_consumed_pulse", consumed, 0);

    // ---- read len=0, arready low 3 cycles ----
    packet = mk_pkt(1'b1, 40'hAB_CDEF_0040, 8'd0, 16'h1234, 16'h0F0F, 8'h05);
    activate = 1'b1;
    m_arready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      activate = 1'b0;
      chk("r_arvalid", m_arvalid, 1);
      chk("r_araddr", m_araddr, 40'hAB_CDEF_0040);
      chk("r_arid", m_arid, 16'h1234);
      chk("r_awvalid", m_awvalid, 0);
      chk("r_wvalid", m_wvalid, 0);
      chk("r_consumed_early", consumed, 0);
      if (i == 4) m_arready = 1'b1;
    end
    chk("r_arlen", m_arlen, 0);
    chk("r_arsize", m_arsize, 4);
    chk("r_arburst", m_arburst, 1);
    chk("r_arlock", m_arlock, 0);
    chk("r_arcache", m_arcache, 3);
    chk("r_arprot", m_arprot, 2);
    chk("r_arqos", m_arqos, 5);
    chk("r_arregion", m_arregion, 6);
    chk("r_aruser", m_aruser, 16'hBEEF);
    @(negedge clock);
    chk("r_consumed", consumed, 1);
    chk("r_arvalid_end", m_arvalid, 0);
    @(negedge clock);
    chk("r_consumed_pulse", consumed, 0);

    // ---- stalls, len field 0x05 -> 2 beats, awlen 1 ----
    packet = mk_pkt(1'b0, 40'h00_0000_1000, 8'h05, 16'h0042, 16'hAAAA, 8'h30);
    m_awready = 1'b0; m_wready = 1'b0;
    activate = 1'b1;
    @(negedge clock);                       // cycle 1
    activate = 1'b0;
    chk("s_awvalid1", m_awvalid, 1);
    chk("s_awlen", m_awlen, 1);
    chk("s_wvalid1", m_wvalid, 0);
    @(negedge clock);                       // cycle 2
    chk("s_awvalid2", m_awvalid, 1);
    chk("s_wvalid2", m_wvalid, 0);
    m_awready = 1'b1;
    @(negedge clock);                       // cycle 3: beat 0, not ready
    m_awready = 1'b0;
    chk("s_awvalid3", m_awvalid, 0);
    chk("s_b0_valid", m_wvalid, 1);
    chk("s_b0_data", m_wdata, bdata(8'h30, 0));
    chk("s_b0_last", m_wlast, 0);
    @(negedge clock);                       // cycle 4: beat 0 held
    chk("s_b0_hold", m_wdata, bdata(8'h30, 0));
    chk("s_b0_hold_valid", m_wvalid, 1);
    m_wready = 1'b1;
    @(negedge clock);                       // cycle 5: beat 1
    chk("s_b1_data", m_wdata, bdata(8'h30, 1));
    chk("s_b1_strb", m_wstrb, 16'hAAAB);
    chk("s_b1_last", m_wlast, 1);
    m_wready = 1'b0;
    @(negedge clock);                       // cycle 6: beat 1 held
    chk("s_b1_hold", m_wdata, bdata(8'h30, 1));
    chk("s_b1_hold_last", m_wlast, 1);
    chk("s_consumed_early", consumed, 0);
    m_wready = 1'b1;
    @(negedge clock);
    chk("s_consumed", consumed, 1);
    chk("s_wvalid_end", m_wvalid, 0);
    m_awready = 1'b1;
    @(negedge clock);
    chk("s_consumed_pulse", consumed, 0);

    // ---- back-to-back with activate held ----
    packet = mk_pkt(1'b0, 40'h00_0000_2000, 8'd0, 16'h0001, 16'hFFFF, 8'h50);
    activate = 1'b1;
    @(negedge clock);                       // cycle 1
    chk("bb_awvalid", m_awvalid, 1);
    @(negedge clock);                       // cycle 2
    chk("bb_wlast", m_wlast, 1);
    chk("bb_wdata", m_wdata, bdata(8'h50, 0));
    @(negedge clock);                       // cycle 3
    chk("bb_consumed1", consumed, 1);
    packet = mk_pkt(1'b1, 40'h00_0000_3000, 8'd0, 16'h0002, 16'hFFFF, 8'h60);
    @(negedge clock);                       // cycle 4: dead cycle
    chk("bb_gap_consumed", consumed, 0);
    chk("bb_gap_arvalid", m_arvalid, 0);
    chk("bb_gap_awvalid", m_awvalid, 0);
    @(negedge clock);                       // cycle 5
    chk("bb_arvalid", m_arvalid, 1);
    chk("bb_araddr", m_araddr, 40'h00_0000_3000);
    chk("bb_no_dup_aw", m_awvalid, 0);
    @(negedge clock);                       // cycle 6
    chk("bb_consumed2", consumed, 1);
    activate = 1'b0;
    @(negedge clock);
    chk("bb_idle_consumed", consumed, 0);
    chk("bb_idle_arvalid", m_arvalid, 0);
    chk("bb_idle_awvalid", m_awvalid, 0);

    // ---- packet changes after capture ----
    packet = mk_pkt(1'b0, 40'h00_0000_4000, 8'd1, 16'h0003, 16'h1111, 8'h70);
    activate = 1'b1;
    @(negedge clock);                       // cycle 1
    activate = 1'b0;
    chk("pc_awvalid", m_awvalid, 1);
    @(negedge clock);                       // cycle 2
    chk("pc_b0", m_wdata, bdata(8'h70, 0));
    packet = mk_pkt(1'b0, 40'h00_0000_9000, 8'd3, 16'h0009, 16'h2222, 8'h90);
    @(negedge clock);                       // cycle 3
    chk("pc_b1", m_wdata, bdata(8'h70, 1));
    chk("pc_b1_strb", m_wstrb, 16'h1110);
    chk("pc_b1_last", m_wlast, 1);
    chk("pc_awaddr", m_awaddr, 40'h00_0000_4000);
    @(negedge clock);
    chk("pc_consumed", consumed, 1);
    @(negedge clock);
    chk("pc_consumed_pulse", consumed, 0);

    // ---- reset during beat 1 of a len=3 write ----
    packet = mk_pkt(1'b0, 40'h00_0000_5000, 8'd3, 16'h0004, 16'hFFFF, 8'h80);
    activate = 1'b1;
    @(negedge clock);                       // cycle 1
    activate = 1'b0;
    @(negedge clock);                       // cycle 2
    @(negedge clock);                       // cycle 3: beat 1
    chk("rm_b1", m_wdata, bdata(8'h80, 1));
    #2 reset = 1'b0;
    #1;
    chk("rm_wvalid", m_wvalid, 0);
    chk("rm_awvalid", m_awvalid, 0);
    chk("rm_arvalid", m_arvalid, 0);
    chk("rm_consumed", consumed, 0);
    chk("rm_wdata", m_wdata, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rm_after_consumed", consumed, 0);
    chk("rm_after_wvalid", m_wvalid, 0);
    packet = mk_pkt(1'b1, 40'h00_0000_6000, 8'd0, 16'h0005, 16'hFFFF, 8'hA0);
    activate = 1'b1;
    @(negedge clock);
    activate = 1'b0;
    chk("rm_new_arvalid", m_arvalid, 1);
    chk("rm_new_araddr", m_araddr, 40'h00_0000_6000);
    @(negedge clock);
    chk("rm_new_consumed", consumed, 1);
    @(negedge clock);
    chk("rm_new_done", consumed, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
